fetch_ctrl: RTL

Sequencer for the instruction-fetch stage of the five-stage pipeline. Generates the PC write-enable, redirect select, and pipeline-register flush/hold controls from load-use hazards, taken branches, exceptions and instruction-memory wait. Buffers a redirect that arrives while fetch is stalled. Sits beside the IF stage and drives its `PcWrite`, `pc_src`, `pc_flush`, `error` and `error_address` inputs, plus the IF/ID and ID/EX register controls.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/hazard_detect.sv | 25 ++
 rtl/fetch_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch-stage sequencer.
// State encodings, handler default and register-index width.
package cpu_pkg;

  localparam int REG_W = 5;

  localparam logic [31:0] HANDLER_ADDR_DEF = 32'h0000_0180;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    IMEM_WAIT = 2'd1,
    EXC_DRAIN = 2'd2,
    EXC_JUMP  = 2'd3
  } state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the load in EX and the ID sources.
// Register 0 never produces a hazard.
module hazard_detect
  import cpu_pkg::*;
(
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  output logic             lu
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = id_use_rs && (id_rs == ex_rt);
  assign rt_hit = id_use_rt && (id_rt == ex_rt);

  assign lu = ex_mem_read
           && (ex_rt != '0)
           && (rs_hit || rt_hit);

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: stalls, redirects and exception drain.
// Outputs are Mealy, combinational from state and this cycle's inputs.
module fetch_ctrl
  import cpu_pkg::*;
#(
  parameter logic [31:0] HANDLER_ADDR = HANDLER_ADDR_DEF,
  parameter int          DRAIN_CYCLES = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             imem_ready,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             br_taken,
  input  logic [31:0]      br_target,
  input  logic             exc_req,
  input  logic [31:0]      exc_pc,
  output logic             pc_write,
  output logic             pc_src,
  output logic [31:0]      redirect_addr,
  output logic             pc_flush,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             error,
  output logic [31:0]      error_address,
  output logic [31:0]      epc
);

  localparam logic [3:0] CNT_INIT = 4'(DRAIN_CYCLES - 1);

  state_t      state;
  state_t      state_n;
  logic [31:0] epc_n;
  logic        pend;
  logic        pend_n;
  logic [31:0] pend_addr;
  logic [31:0] pend_addr_n;
  logic [3:0]  cnt;
  logic [3:0]  cnt_n;
  logic        lu;

  hazard_detect u_hazard (
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_use_rs   (id_use_rs),
    .id_use_rt   (id_use_rt),
    .lu          (lu)
  );

  assign error_address = HANDLER_ADDR;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      epc       <= '0;
      pend      <= 1'b0;
      pend_addr <= '0;
      cnt       <= '0;
    end else begin
      state     <= state_n;
      epc       <= epc_n;
      pend      <= pend_n;
      pend_addr <= pend_addr_n;
      cnt       <= cnt_n;
    end
  end

  always_comb begin
    state_n       = state;
    epc_n         = epc;
    pend_n        = pend;
    pend_addr_n   = pend_addr;
    cnt_n         = cnt;
    pc_write      = 1'b0;
    pc_src        = 1'b0;
    redirect_addr = br_target;
    pc_flush      = 1'b0;
    if_id_write   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    error         = 1'b0;

    unique case (state)
      RUN, IMEM_WAIT: begin
        if (exc_req) begin
          epc_n       = exc_pc;
          cnt_n       = CNT_INIT;
          pend_n      = 1'b0;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          state_n     = EXC_DRAIN;
        end else if (state == RUN) begin
          pc_write    = 1'b1;
          if_id_write = 1'b1;
          if (br_taken && imem_ready) begin
            pc_src      = 1'b1;
            if_id_flush = 1'b1;
          end else if (br_taken) begin
            pend_n      = 1'b1;
            pend_addr_n = br_target;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            pc_flush    = 1'b1;
            state_n     = IMEM_WAIT;
          end else if (lu) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
          end else if (!imem_ready) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            pc_flush    = 1'b1;
            state_n     = IMEM_WAIT;
          end
        end else begin
          // Latest branch seen while waiting wins the redirect
          if (br_taken) begin
            pend_n      = 1'b1;
            pend_addr_n = br_target;
          end
          if (imem_ready) begin
            state_n  = RUN;
            pend_n   = 1'b0;
            pc_write = 1'b1;
            if (pend || br_taken) begin
              pc_src        = 1'b1;
              redirect_addr = br_taken ? br_target : pend_addr;
              if_id_flush   = 1'b1;
            end else begin
              if_id_write = 1'b1;
            end
          end else begin
            pc_flush    = 1'b1;
            id_ex_flush = lu;
          end
        end
      end
      EXC_DRAIN: begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        if (cnt == 4'd0) begin
          state_n = EXC_JUMP;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      EXC_JUMP: begin
        if (imem_ready) begin
          error       = 1'b1;
          pc_write    = 1'b1;
          if_id_flush = 1'b1;
          state_n     = RUN;
        end else begin
          pc_flush = 1'b1;
        end
      end
    endcase

    if (reset) begin
      pc_write    = 1'b0;
      pc_src      = 1'b0;
      pc_flush    = 1'b0;
      if_id_write = 1'b0;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      error       = 1'b0;
    end
  end

endmodule
